riscv_core_immgen: RTL and testbench

Registered, handshaked immediate generator for the decode stage of the RV32IMC core. It is the successor to the combinational immediate extender. It is parametrised in XLEN (32/64) and decodes all base-ISA and C-extension immediate formats from the raw instruction word. A one-entry skid buffer gives a fully registered `o_immgen_ready`, and the block supports pipeline flush and reserved-encoding detection.

---
 rtl/riscv_core_immgen.sv | 196 +++++++++++++++++++
 tb/tb_riscv_core_immgen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_immgen.sv
// riscv_core_immgen: registered, handshaked immediate generator for the
// RV32IMC decode stage. It decodes the base-ISA and compressed immediate
// formats from the raw instruction word and extends them to XLEN. A main
// register plus a one-entry skid register keep o_immgen_ready fully
// registered, with no combinational path from i_immgen_ready.
module riscv_core_immgen #(
  parameter int XLEN = 32,
  parameter int EN_C = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_immgen_valid,
  output logic            o_immgen_ready,
  input  logic [31:0]     i_immgen_instr,
  input  logic [3:0]      i_immgen_immsrc,
  input  logic            i_immgen_flush,
  output logic            o_immgen_valid,
  input  logic            i_immgen_ready,
  output logic [XLEN-1:0] o_immgen_imm,
  output logic            o_immgen_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic C_ENABLED = (EN_C != 32'sd0) ? 1'b1 : 1'b0;

  // Format decode. Every format is first built as a 32-bit value whose
  // upper bits already carry the correct sign or zero extension, so one
  // common step widens it to XLEN afterwards. Zero-extended formats have
  // bit 31 clear, so sign-extending them again is harmless.
  function automatic logic [31:0] imm_raw32(input logic [31:0] ins,
                                            input logic [3:0]  src);
    logic [31:0] r;
    r = 32'd0;
    case (src)
      4'd0:  r = {{20{ins[31]}}, ins[31:20]};
      4'd1:  r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      4'd2:  r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      4'd3:  r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      4'd4:  r = {ins[31:12], 12'd0};
      4'd5:  r = 32'd0;
      4'd6:  r = {27'd0, ins[19:15]};
      4'd7:  r = {{26{ins[12]}}, ins[12], ins[6:2]};
      4'd8:  r = {24'd0, ins[3:2], ins[12], ins[6:4], 2'b00};
      4'd9:  r = {24'd0, ins[8:7], ins[12:9], 2'b00};
      4'd10: r = {25'd0, ins[5], ins[12:10], ins[6], 2'b00};
      4'd11: r = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                  ins[2], ins[11], ins[5:3], 1'b0};
      4'd12: r = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10],
                  ins[4:3], 1'b0};
      4'd13: r = {22'd0, ins[10:7], ins[12:11], ins[5], ins[6], 2'b00};
      4'd14: r = {{22{ins[12]}}, ins[12], ins[4:3], ins[5], ins[2], ins[6],
                  4'd0};
      4'd15: r = {{14{ins[12]}}, ins[12], ins[6:2], 12'd0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reserved-encoding check: compressed formats when C is disabled, and
  // the nz-immediate formats (ADDI4SPN, ADDI16SP, LUI) with a zero value.
  function automatic logic imm_illegal(input logic [3:0]  src,
                                       input logic [31:0] raw);
    logic ill;
    ill = 1'b0;
    if ((src >= 4'd7) && !C_ENABLED) begin
      ill = 1'b1;
    end else if ((src >= 4'd13) && (raw == 32'd0)) begin
      ill = 1'b1;
    end else begin
      ill = 1'b0;
    end
    return ill;
  endfunction

  logic [31:0]     imm_raw_s;
  logic [XLEN-1:0] imm_ext_s;
  logic [XLEN-1:0] new_imm_s;
  logic            new_ill_s;
  logic            accept_s;
  logic            drain_s;
  logic            unused_s;

  state_e          state_r;
  logic            m_valid_r;
  logic [XLEN-1:0] m_imm_r;
  logic            m_ill_r;
  logic            s_valid_r;
  logic [XLEN-1:0] s_imm_r;
  logic            s_ill_r;

  // The two compressed-opcode bits never take part in any immediate.
  assign unused_s = ^i_immgen_instr[1:0];

  assign imm_raw_s = imm_raw32(i_immgen_instr, i_immgen_immsrc);

  generate
    if (XLEN == 64) begin : g_x64
      assign imm_ext_s = {{32{imm_raw_s[31]}}, imm_raw_s};
    end else begin : g_x32
      assign imm_ext_s = imm_raw_s;
    end
  endgenerate

  // Illegal entries carry a forced-zero immediate.
  always_comb begin
    new_ill_s = imm_illegal(i_immgen_immsrc, imm_raw_s);
    new_imm_s = {XLEN{1'b0}};
    if (new_ill_s) begin
      new_imm_s = {XLEN{1'b0}};
    end else begin
      new_imm_s = imm_ext_s;
    end
  end

  assign accept_s = i_immgen_valid & ~s_valid_r;
  assign drain_s  = m_valid_r & i_immgen_ready;

  // Main/skid storage state machine; flush beats every other event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_EMPTY;
      m_valid_r <= 1'b0;
      m_imm_r   <= {XLEN{1'b0}};
      m_ill_r   <= 1'b0;
      s_valid_r <= 1'b0;
      s_imm_r   <= {XLEN{1'b0}};
      s_ill_r   <= 1'b0;
    end else if (i_immgen_flush) begin
      state_r   <= ST_EMPTY;
      m_valid_r <= 1'b0;
      m_imm_r   <= {XLEN{1'b0}};
      m_ill_r   <= 1'b0;
      s_valid_r <= 1'b0;
      s_imm_r   <= {XLEN{1'b0}};
      s_ill_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r   <= ST_ONE;
            m_valid_r <= 1'b1;
            m_imm_r   <= new_imm_s;
            m_ill_r   <= new_ill_s;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            m_imm_r <= new_imm_s;
            m_ill_r <= new_ill_s;
          end else if (accept_s) begin
            state_r   <= ST_FULL;
            s_valid_r <= 1'b1;
            s_imm_r   <= new_imm_s;
            s_ill_r   <= new_ill_s;
          end else if (drain_s) begin
            state_r   <= ST_EMPTY;
            m_valid_r <= 1'b0;
            m_imm_r   <= {XLEN{1'b0}};
            m_ill_r   <= 1'b0;
          end
        end
        ST_FULL: begin
          // The skid register is full, so no accept can happen here.
          if (drain_s) begin
            state_r   <= ST_ONE;
            m_imm_r   <= s_imm_r;
            m_ill_r   <= s_ill_r;
            s_valid_r <= 1'b0;
            s_imm_r   <= {XLEN{1'b0}};
            s_ill_r   <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          m_valid_r <= 1'b0;
          m_imm_r   <= {XLEN{1'b0}};
          m_ill_r   <= 1'b0;
          s_valid_r <= 1'b0;
          s_imm_r   <= {XLEN{1'b0}};
          s_ill_r   <= 1'b0;
        end
      endcase
    end
  end

  assign o_immgen_ready   = ~s_valid_r;
  assign o_immgen_valid   = m_valid_r;
  assign o_immgen_imm     = m_imm_r;
  assign o_immgen_illegal = m_ill_r;

endmodule

// File: tb/tb_riscv_core_immgen.sv
// Scoreboard bench for riscv_core_immgen. Three instances (XLEN=32,
// XLEN=64, XLEN=32 with C disabled) share one stimulus stream and move in
// lockstep; each queue entry holds the expected result for all three.
module tb_riscv_core_immgen;

  logic        clk;
  logic        rst_n;
  logic        dv;
  logic [31:0] dinstr;
  logic [3:0]  dsrc;
  logic        dflush;
  logic        dn_ready;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic        rdync, vnc, illnc;
  logic [31:0] immnc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
    logic [31:0] enc;
    logic        inc;
  } exp_t;

  exp_t sb[$];

  // Hand-computed vectors: instr, immsrc, XLEN=32 result, XLEN=64 result, illegal
  localparam int NV = 21;
  logic [31:0] v_instr [NV] = '{
    32'hFFF00093, 32'h123450B7, 32'h800000B7, 32'h000F8073, 32'h02000223,
    32'h80000063, 32'h0040006F, 32'hFFFFFFFF, 32'h00000014, 32'h0000107C,
    32'h0000107C, 32'h00000300, 32'h00000420, 32'h0000BFFD, 32'h00001000,
    32'h00000020, 32'h00000000, 32'h00000040, 32'h00001000, 32'h00000000,
    32'h00000000};
  logic [3:0] v_src [NV] = '{
    4'd0, 4'd4, 4'd4, 4'd6, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd7,
    4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd13, 4'd14, 4'd15, 4'd15,
    4'd14};
  logic [31:0] v_e32 [NV] = '{
    32'hFFFFFFFF, 32'h12345000, 32'h80000000, 32'h0000001F, 32'h00000024,
    32'hFFFFF000, 32'h00000004, 32'h00000000, 32'h00000005, 32'hFFFFFFFF,
    32'h000000FC, 32'h00000084, 32'h00000048, 32'hFFFFFFFE, 32'hFFFFFF00,
    32'h00000008, 32'h00000000, 32'h00000010, 32'hFFFE0000, 32'h00000000,
    32'h00000000};
  logic [63:0] v_e64 [NV] = '{
    64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000, 64'hFFFFFFFF80000000,
    64'h000000000000001F, 64'h0000000000000024, 64'hFFFFFFFFFFFFF000,
    64'h0000000000000004, 64'h0000000000000000, 64'h0000000000000005,
    64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FC, 64'h0000000000000084,
    64'h0000000000000048, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFF00,
    64'h0000000000000008, 64'h0000000000000000, 64'h0000000000000010,
    64'hFFFFFFFFFFFE0000, 64'h0000000000000000, 64'h0000000000000000};
  logic v_ill [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
    1'b1};

  riscv_core_immgen #(.XLEN(32), .EN_C(1)) d32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_immgen_valid(dv), .o_immgen_ready(rdy32),
    .i_immgen_instr(dinstr), .i_immgen_immsrc(dsrc), .i_immgen_flush(dflush),
    .o_immgen_valid(v32), .i_immgen_ready(dn_ready), .o_immgen_imm(imm32),
    .o_immgen_illegal(ill32));

  riscv_core_immgen #(.XLEN(64), .EN_C(1)) d64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_immgen_valid(dv), .o_immgen_ready(rdy64),
    .i_immgen_instr(dinstr), .i_immgen_immsrc(dsrc), .i_immgen_flush(dflush),
    .o_immgen_valid(v64), .i_immgen_ready(dn_ready), .o_immgen_imm(imm64),
    .o_immgen_illegal(ill64));

  riscv_core_immgen #(.XLEN(32), .EN_C(0)) dnc (
    .i_clk(clk), .i_rst_n(rst_n), .i_immgen_valid(dv), .o_immgen_ready(rdync),
    .i_immgen_instr(dinstr), .i_immgen_immsrc(dsrc), .i_immgen_flush(dflush),
    .o_immgen_valid(vnc), .i_immgen_ready(dn_ready), .o_immgen_imm(immnc),
    .o_immgen_illegal(illnc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever an output entry is delivered.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && v32 && dn_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", imm32);
      end else begin
        e = sb.pop_front();
        chk("imm32", {32'd0, imm32}, {32'd0, e.e32});
        chk("ill32", {63'd0, ill32}, {63'd0, e.ill});
        chk("valid64", {63'd0, v64}, 64'd1);
        chk("imm64", imm64, e.e64);
        chk("ill64", {63'd0, ill64}, {63'd0, e.ill});
        chk("valid_noc", {63'd0, vnc}, 64'd1);
        chk("imm_noc", {32'd0, immnc}, {32'd0, e.enc});
        chk("ill_noc", {63'd0, illnc}, {63'd0, e.inc});
      end
    end
  end

  // Present vector k and wait for acceptance; the expectation is queued
  // in the cycle the handshake completes.
  task automatic send(input int k);
    exp_t e;
    bit done;
    done = 1'b0;
    dv = 1'b1;
    dinstr = v_instr[k];
    dsrc = v_src[k];
    e.e32 = v_e32[k];
    e.e64 = v_e64[k];
    e.ill = v_ill[k];
    if (v_src[k] >= 4'd7) begin
      e.enc = 32'd0;
      e.inc = 1'b1;
    end else begin
      e.enc = v_e32[k];
      e.inc = v_ill[k];
    end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (rdy32) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    dv = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted vec=%0d", k);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk);
      #2;
    end
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    dv = 1'b0;
    dinstr = 32'd0;
    dsrc = 4'd0;
    dflush = 1'b0;
    dn_ready = 1'b1;
    #1;
    chk("rst_valid", {63'd0, v32}, 64'd0);
    chk("rst_imm", {32'd0, imm32}, 64'd0);
    chk("rst_ill", {63'd0, ill32}, 64'd0);
    chk("rst_ready", {63'd0, rdy32}, 64'd1);
    chk("rst_imm64", imm64, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming all formats back-to-back; first result one cycle after accept
    send(0);
    chk("latency_valid", {63'd0, v32}, 64'd1);
    for (int k = 1; k < NV; k++) send(k);
    wait_drain();

    // Backpressure: A and B accepted, C held until release
    dn_ready = 1'b0;
    send(1);
    send(2);
    dv = 1'b1;
    dinstr = v_instr[13];
    dsrc = v_src[13];
    @(negedge clk);
    chk("bp_ready_low", {63'd0, rdy32}, 64'd0);
    chk("bp_valid_held", {63'd0, v32}, 64'd1);
    chk("bp_imm_held", {32'd0, imm32}, {32'd0, v_e32[1]});
    @(posedge clk);
    #1;
    dn_ready = 1'b1;
    send(13);
    wait_drain();

    // Flush from FULL with a same-cycle request that must be dropped
    dn_ready = 1'b0;
    send(4);
    send(5);
    chk("flush_pre_full", {63'd0, rdy32}, 64'd0);
    dv = 1'b1;
    dinstr = v_instr[6];
    dsrc = v_src[6];
    dflush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    dflush = 1'b0;
    dv = 1'b0;
    chk("flush_valid", {63'd0, v32}, 64'd0);
    chk("flush_ready", {63'd0, rdy32}, 64'd1);
    dn_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset between edges while holding one entry
    dn_ready = 1'b0;
    send(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, v32}, 64'd0);
    chk("arst_imm", {32'd0, imm32}, 64'd0);
    chk("arst_ill", {63'd0, ill32}, 64'd0);
    chk("arst_ready", {63'd0, rdy32}, 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dn_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3);
    chk("post_rst_latency", {63'd0, v32}, 64'd1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
